// File: rtl/osiris_wb_defs.sv
// rtl/osiris_wb_defs.sv - shared Wishbone arbiter state encodings and master indices
package osiris_wb_defs;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    localparam int WB_M_CORE = 0;
    localparam int WB_M_UART = 1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int DEFAULT_TIMEOUT_WIDTH  = 8;

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - bus timeout counter with clear/enable/expire
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = osiris_wb_defs::DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = osiris_wb_defs::DEFAULT_TIMEOUT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [TIMEOUT_WIDTH-1:0] LP_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    // Count unacknowledged strobe cycles; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == LP_LIMIT);

endmodule

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master round-robin Wishbone arbiter for data memory
module wb_mem_arbiter
    import osiris_wb_defs::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = DEFAULT_TIMEOUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic                  o_core_stall,
    output logic [1:0]            o_grant
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last;
    logic       w_next_last;

    logic w_gnt0;
    logic w_gnt1;
    logic w_expire;
    logic w_tmo_clear;
    logic w_tmo_enable;

    // While reset is held every grant-derived output is forced to its idle value.
    assign w_gnt0 = rst && (r_state == ARB_GNT0);
    assign w_gnt1 = rst && (r_state == ARB_GNT1);

    // Arbiter state and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
        end
    end

    // Next-state: grant on cyc, hold for the owner's whole cycle, leave on release or timeout.
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        case (r_state)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next_state = r_last ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cyc_i) begin
                    w_next_state = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    w_next_state = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (!m0_cyc_i || w_expire) begin
                    w_next_state = ARB_IDLE;
                    w_next_last  = 1'(WB_M_CORE);
                end
            end
            ARB_GNT1: begin
                if (!m1_cyc_i || w_expire) begin
                    w_next_state = ARB_IDLE;
                    w_next_last  = 1'(WB_M_UART);
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // Route the owner's request to memory; an expiring cycle has its cyc/stb dropped.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (w_gnt0) begin
            s_cyc_o = m0_cyc_i && !w_expire;
            s_stb_o = m0_stb_i && !w_expire;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (w_gnt1) begin
            s_cyc_o = m1_cyc_i && !w_expire;
            s_stb_o = m1_stb_i && !w_expire;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = w_gnt0 && s_ack_i && !w_expire;
    assign m1_ack_o = w_gnt1 && s_ack_i && !w_expire;
    assign m0_err_o = w_gnt0 && w_expire;
    assign m1_err_o = w_gnt1 && w_expire;

    assign o_grant      = {w_gnt1, w_gnt0};
    assign o_core_stall = m0_stb_i && !(w_gnt0 && s_ack_i) && !m0_err_o;

    // Idle clears the count so every new grant starts from zero.
    assign w_tmo_clear  = (r_state == ARB_IDLE) || s_ack_i;
    assign w_tmo_enable = s_stb_o && !s_ack_i;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_expire (w_expire)
    );

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - scoreboard bench for wb_mem_arbiter
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [9:0]  m0_adr;
    logic [31:0] m0_dat;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc, m1_stb, m1_we;
    logic [9:0]  m1_adr;
    logic [31:0] m1_dat;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [9:0]  s_adr_o;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        o_core_stall;
    logic [1:0]  o_grant;

    logic        mem_ack_en;
    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        is_err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    wb_mem_arbiter #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (10),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_WIDTH  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_cyc_i     (m0_cyc),
        .m0_stb_i     (m0_stb),
        .m0_we_i      (m0_we),
        .m0_adr_i     (m0_adr),
        .m0_dat_i     (m0_dat),
        .m0_dat_o     (m0_dat_o),
        .m0_ack_o     (m0_ack_o),
        .m0_err_o     (m0_err_o),
        .m1_cyc_i     (m1_cyc),
        .m1_stb_i     (m1_stb),
        .m1_we_i      (m1_we),
        .m1_adr_i     (m1_adr),
        .m1_dat_i     (m1_dat),
        .m1_dat_o     (m1_dat_o),
        .m1_ack_o     (m1_ack_o),
        .m1_err_o     (m1_err_o),
        .s_cyc_o      (s_cyc_o),
        .s_stb_o      (s_stb_o),
        .s_we_o       (s_we_o),
        .s_adr_o      (s_adr_o),
        .s_dat_o      (s_dat_o),
        .s_dat_i      (s_dat_i),
        .s_ack_i      (s_ack_i),
        .o_core_stall (o_core_stall),
        .o_grant      (o_grant)
    );

    // zero-wait memory: ack in the strobe cycle, write on the closing edge
    assign s_ack_i = mem_ack_en && s_cyc_o && s_stb_o;
    assign s_dat_i = mem[s_adr_o];

    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && s_ack_i && s_we_o)
            mem[s_adr_o] <= s_dat_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // monitor: pop the expected response whenever a master sees ack or err
    always @(negedge clk) begin
        exp_t e;
        if (m0_ack_o || m0_err_o) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL m0_unexpected: got ack=%0b err=%0b required none", m0_ack_o, m0_err_o);
            end else begin
                e = q0.pop_front();
                chk("m0_resp_err", 32'(m0_err_o), 32'(e.is_err));
                if (e.chk_data && !e.is_err)
                    chk("m0_rdata", m0_dat_o, e.data);
            end
        end
        if (m1_ack_o || m1_err_o) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL m1_unexpected: got ack=%0b err=%0b required none", m1_ack_o, m1_err_o);
            end else begin
                e = q1.pop_front();
                chk("m1_resp_err", 32'(m1_err_o), 32'(e.is_err));
                if (e.chk_data && !e.is_err)
                    chk("m1_rdata", m1_dat_o, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b0;
        mem_ack_en = 1'b1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat = '0;

        // reset held with both cyc high
        m0_cyc = 1'b1;
        m1_cyc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_grant", 32'(o_grant), 32'd0);
            chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("first_grant", 32'(o_grant), 32'd1);
        m0_cyc = 1'b0;
        m1_cyc = 1'b0;
        tick();
        chk("release_idle", 32'(o_grant), 32'd0);

        // single core write then read-back
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 10'h004; m0_dat = 32'hDEADBEEF;
        q0.push_back('{1'b0, 1'b0, 32'h0});
        #1;
        chk("wr_stall_req", 32'(o_core_stall), 32'd1);
        chk("wr_grant_idle", 32'(o_grant), 32'd0);
        tick();
        chk("wr_grant", 32'(o_grant), 32'd1);
        chk("wr_s_we", 32'(s_we_o), 32'd1);
        chk("wr_s_adr", 32'(s_adr_o), 32'h004);
        chk("wr_stall_ack", 32'(o_core_stall), 32'd0);
        tick();
        m0_we = 1'b0;
        q0.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        #1;
        chk("rd_stall_ack", 32'(o_core_stall), 32'd0);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        chk("wr_done_idle", 32'(o_grant), 32'd0);

        // contention: first tie goes to m0
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 10'h004;
        q0.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 10'h008; m1_dat = 32'h12345678;
        q1.push_back('{1'b0, 1'b0, 32'h0});
        tick();
        chk("tie1_grant_m0", 32'(o_grant), 32'd1);
        chk("tie1_m1_noack_g", 32'(m1_ack_o), 32'd0);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        chk("tie1_grant_k", 32'(o_grant), 32'd1);
        chk("tie1_m1_noack_k", 32'(m1_ack_o), 32'd0);
        tick();
        chk("tie1_bubble", 32'(o_grant), 32'd0);
        chk("tie1_m1_noack_b", 32'(m1_ack_o), 32'd0);
        tick();
        chk("tie1_grant_m1", 32'(o_grant), 32'd2);
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        tick();

        // core reads back the uart write, leaving last = m0
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 10'h008;
        q0.push_back('{1'b0, 1'b1, 32'h12345678});
        tick();
        chk("rd8_grant", 32'(o_grant), 32'd1);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();

        // second tie goes to m1, which bursts 4 writes while m0 waits
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 10'h002;
        q0.push_back('{1'b0, 1'b1, 32'hA0000002});
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 10'h000; m1_dat = 32'hA0000000;
        q1.push_back('{1'b0, 1'b0, 32'h0});
        tick();
        chk("tie2_grant_m1", 32'(o_grant), 32'd2);
        chk("burst_stall_0", 32'(o_core_stall), 32'd1);
        chk("burst_m0_noack", 32'(m0_ack_o), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            m1_adr = 10'(i);
            m1_dat = 32'hA0000000 + 32'(i);
            q1.push_back('{1'b0, 1'b0, 32'h0});
            #1;
            chk("burst_stall", 32'(o_core_stall), 32'd1);
            chk("burst_grant", 32'(o_grant), 32'd2);
        end
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        #1;
        chk("burst_rel_stall", 32'(o_core_stall), 32'd1);
        tick();
        chk("burst_bubble", 32'(o_grant), 32'd0);
        chk("burst_bubble_stall", 32'(o_core_stall), 32'd1);
        tick();
        chk("burst_m0_grant", 32'(o_grant), 32'd1);
        chk("burst_m0_stall", 32'(o_core_stall), 32'd0);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();

        // timeout with a slave that never acks
        mem_ack_en = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 10'h010; m0_dat = 32'h00000055;
        q0.push_back('{1'b1, 1'b0, 32'h0});
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("tmo_err", 32'(m0_err_o), (k == 4) ? 32'd1 : 32'd0);
            chk("tmo_stall", 32'(o_core_stall), (k == 4) ? 32'd0 : 32'd1);
            chk("tmo_s_stb", 32'(s_stb_o), (k == 4) ? 32'd0 : 32'd1);
            chk("tmo_grant", 32'(o_grant), 32'd1);
            if (k < 4) tick();
        end
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        #1;
        chk("tmo_idle", 32'(o_grant), 32'd0);
        chk("tmo_err_once", 32'(m0_err_o), 32'd0);
        mem_ack_en = 1'b1;
        tick();

        // reset while m1 owns the bus with an ack pending
        mem_ack_en = 1'b0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 10'h020; m1_dat = 32'h00000077;
        m0_stb = 1'b1;
        tick();
        chk("mid_grant_m1", 32'(o_grant), 32'd2);
        rst = 1'b0;
        mem_ack_en = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(m1_ack_o), 32'd0);
        chk("mid_rst_err", 32'(m1_err_o), 32'd0);
        chk("mid_rst_grant", 32'(o_grant), 32'd0);
        chk("mid_rst_stall", 32'(o_core_stall), 32'd1);
        tick();
        chk("post_grant", 32'(o_grant), 32'd0);
        chk("post_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("post_s_stb", 32'(s_stb_o), 32'd0);
        chk("post_s_we", 32'(s_we_o), 32'd0);
        chk("post_s_adr", 32'(s_adr_o), 32'd0);
        chk("post_s_dat", s_dat_o, 32'd0);
        chk("post_m1_ack", 32'(m1_ack_o), 32'd0);
        chk("post_m1_err", 32'(m1_err_o), 32'd0);
        chk("post_m0_ack", 32'(m0_ack_o), 32'd0);
        chk("post_m1_dat", m1_dat_o, 32'hA0000000);
        chk("post_m0_dat", m0_dat_o, 32'hA0000000);
        rst = 1'b1;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        m0_stb = 1'b0;
        tick();
        chk("end_idle", 32'(o_grant), 32'd0);
        tick();
        tick();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-master, one-slave Wishbone classic arbiter that shares one `mem` instance between the core's load/store port (master 0) and the UART Wishbone bridge (master 1). It replaces the static `i_select_mem`/strobe mux on the data-memory path with registered round-robin grant, grant hold for the owner's whole cycle, a bus timeout, and a stall output that freezes the core while it waits for data memory.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 10, word address width (matches `mem` address port)
- `TIMEOUT_CYCLES`, 255, cycles of `stb` without `ack` before abort; must be ≥ 1
- `TIMEOUT_WIDTH`, 8, counter width; must satisfy `2**TIMEOUT_WIDTH > TIMEOUT_CYCLES`

Ports:
- `clk` in 1: the block's only clock
- `rst` in 1: reset, synchronous, active-low
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: core request
- `m0_adr_i` in ADDR_WIDTH, `m0_dat_i` in DATA_WIDTH: core address / write data
- `m0_dat_o` out DATA_WIDTH, `m0_ack_o` out 1, `m0_err_o` out 1: core response
- `m1_cyc_i`, `m1_stb_i`, `m1_we_i`, `m1_adr_i`, `m1_dat_i`: UART bridge request, same widths
- `m1_dat_o`, `m1_ack_o`, `m1_err_o`: UART bridge response, same widths
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each; `s_adr_o` out ADDR_WIDTH; `s_dat_o` out DATA_WIDTH: to memory
- `s_dat_i` in DATA_WIDTH, `s_ack_i` in 1: from memory
- `o_core_stall` out 1: core must hold its M stage
- `o_grant` out 2: one-hot current owner, bit0 = m0, bit1 = m1

## Operation
- FSM states: IDLE, GNT0, GNT1.
- IDLE: no slave signals driven; the master with `cyc` high wins. If both are high, the master not granted last wins. The `last` register resets to 1, so m0 wins the first tie.
- GNTx: `s_cyc/stb/we/adr/dat` follow master x combinationally. `s_ack_i` is routed to `mx_ack_o` only; the other master's ack is 0.
- `s_dat_i` is broadcast to both `m*_dat_o`. Masters qualify it with their own ack.
- GNTx → IDLE when `mx_cyc_i` is low. Ownership is held across multiple strobes while `cyc` stays high (bursts allowed). `last` is set to x on leaving.
- Timeout:
  - The counter clears on entering GNTx and on each `s_ack_i`.
  - It increments each cycle with `s_stb_o` high and `s_ack_i` low.
  - When it equals TIMEOUT_CYCLES, `mx_err_o` pulses for one cycle, `s_cyc_o`/`s_stb_o` are forced low that cycle, and the FSM goes to IDLE with `last` = x.
- `o_core_stall` = `m0_stb_i` & ~(GNT0 & `s_ack_i`) & ~`m0_err_o`.
- No combinational path from `m*_cyc_i` to `o_grant`; grant changes only on a clock edge.

## Timing
- Reset (`rst` low at edge): FSM goes to IDLE, counter 0, `last` = 1. In the same cycle as reset: `o_grant` = 0, all `s_*_o` = 0, all acks and errs = 0, `m*_dat_o` = `s_dat_i`. `o_core_stall` still follows `m0_stb_i`, so it is 1 if the core is requesting.
- Grant latency: request seen in IDLE at edge N; `o_grant` and slave signals are valid in cycle N+1.
- Ack path: `s_ack_i` → `mx_ack_o` is combinational, zero cycles.
- Release: the owner drops `cyc` in cycle K; the FSM is IDLE in K+1. A pending request from the other master is granted at K+2, giving exactly one bubble cycle.
- Simultaneous release and new request: IDLE for one cycle, then grant by round-robin.
- Reset mid-cycle: the transaction is abandoned with no ack or err issued. Masters re-request after reset.
- Timeout: first unacked strobe cycle is T0; `mx_err_o` is high in cycle T0+TIMEOUT_CYCLES; the FSM is IDLE the next cycle.

## Structure
- Shared package/header `osiris_wb_defs`:
  - state encodings `ARB_IDLE = 2'd0`, `ARB_GNT0 = 2'd1`, `ARB_GNT1 = 2'd2`
  - master indices `WB_M_CORE = 0`, `WB_M_UART = 1`
  - default `TIMEOUT_CYCLES`
- One sub-module, `wb_timeout_counter`: clear/enable/expire interface, parameterised by TIMEOUT_CYCLES/TIMEOUT_WIDTH, reusable for the instruction-memory path.
- All muxing and the FSM stay in `wb_mem_arbiter`.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with both `cyc` = 1. Required: `o_grant` = 0 and `s_cyc_o` = 0 throughout; the first grant after release is `o_grant` = 01.
- Single core write: m0 writes 0xDEADBEEF to address 0x004 with 1-cycle-ack memory. Required: grant next cycle; `o_core_stall` high until the ack cycle; read-back returns 0xDEADBEEF.
- Contention:
  - Both request in the same cycle. Required: m0 granted first; m1 granted two cycles after m0 drops `cyc`; m1 sees no ack during GNT0.
  - Repeat the tie. Required: m1 wins.
- Burst hold: m1 holds `cyc` over 4 strobes to addresses 0x000–0x003 while m0 requests. Required: m0 stays stalled; all 4 acks go to m1; m0 is granted after release.
- Timeout: TIMEOUT_CYCLES = 4, slave never acks. Required: `m0_err_o` high exactly 4 cycles after the first strobe, lasting 1 cycle; `o_core_stall` low that cycle; FSM IDLE afterwards.
- Reset mid-transaction: assert `rst` while in GNT1 with ack pending. Required: no ack or err issued; all outputs are at reset values in the cycle after the edge.
